// File: rtl/inst_fetch_cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : inst_fetch_cache_pkg
//  Brief   : Shared sizes and state encoding for the instruction fetch cache.
//  Rev     : 1.0  initial release
// ============================================================================
package inst_fetch_cache_pkg;

  localparam int c_word_size     = 32;
  localparam int c_block_size    = 512;
  localparam int c_byte_size     = 8;
  localparam int c_line_off_bits = 7;
  localparam int c_line_bits     = 2 * c_block_size;

  typedef enum logic [1:0] {
    IFC_IDLE  = 2'd0,
    IFC_MREQ  = 2'd1,
    IFC_MFILL = 2'd2
  } ifc_state_e;

endpackage : inst_fetch_cache_pkg
`default_nettype wire

// File: rtl/inst_fetch_cache_word_select.sv
`default_nettype none
// ============================================================================
//  Module  : ifc_word_select
//  Brief   : Picks the aligned 32-bit word at a byte offset from a cache line.
//            Bytes are big-endian: byte 0 of the line is its MSB byte, and the
//            addressed byte becomes the MSB of the returned word.
//  Rev     : 1.0  initial release
// ============================================================================
module ifc_word_select
  import inst_fetch_cache_pkg::*;
#(
  parameter int OFF_BITS  = c_line_off_bits,
  parameter int LINE_BITS = c_line_bits
) (
  input  logic [LINE_BITS-1:0]   line,
  input  logic [OFF_BITS-1:0]    off,
  output logic [c_word_size-1:0] word
);

  // The two low offset bits never affect the result; words are always aligned.
  logic [1:0]           w_unused_lsb;
  logic [OFF_BITS-1:0]  w_aligned;
  logic [LINE_BITS-1:0] w_shifted;

  assign w_unused_lsb = off[1:0];
  assign w_aligned    = {off[OFF_BITS-1:2], 2'b00};

  // Shift the addressed byte up to the top of the line, then take the top word.
  assign w_shifted = line << {w_aligned, 3'b000};
  assign word      = w_shifted[LINE_BITS-1 -: c_word_size];

endmodule : ifc_word_select
`default_nettype wire

// File: rtl/inst_fetch_cache.sv
`default_nettype none
// ============================================================================
//  Module  : inst_fetch_cache
//  Brief   : Direct-mapped instruction cache with 128-byte lines. Serves hits
//            in one cycle; misses read one line from instmem (two half-line
//            beats returned together) and complete three cycles after request.
//  Rev     : 1.0  initial release
// ============================================================================
module inst_fetch_cache
  import inst_fetch_cache_pkg::*;
#(
  parameter int LINES    = 4,
  parameter int OFF_BITS = c_line_off_bits
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req,
  input  logic [c_word_size-1:0]  cpu_pc,
  input  logic                    flush,
  output logic                    cpu_ready,
  output logic                    inst_valid,
  output logic [c_word_size-1:0]  inst,
  output logic [c_word_size-1:0]  mem_in,
  output logic                    mem_readable,
  output logic                    mem_writable,
  output logic [c_block_size-1:0] mem_write,
  input  logic [c_block_size-1:0] mem_out1,
  input  logic [c_block_size-1:0] mem_out2
);

  localparam int c_idx_bits = $clog2(LINES);
  localparam int c_tag_bits = c_word_size - OFF_BITS - c_idx_bits;

  ifc_state_e                r_state;
  logic [c_word_size-1:0]    r_pc;
  logic [LINES-1:0]          r_valid;
  logic [c_tag_bits-1:0]     r_tag  [LINES];
  logic [c_line_bits-1:0]    r_data [LINES];

  logic [c_idx_bits-1:0]     w_idx;
  logic [c_tag_bits-1:0]     w_tag;
  logic [c_idx_bits-1:0]     w_fidx;
  logic                      w_hit;
  logic                      w_filling;
  logic [c_line_bits-1:0]    w_sel_line;
  logic [OFF_BITS-1:0]       w_sel_off;
  logic [c_word_size-1:0]    w_word;

  // This cache never writes instruction memory.
  assign mem_writable = 1'b0;
  assign mem_write    = '0;

  assign w_idx  = cpu_pc[OFF_BITS +: c_idx_bits];
  assign w_tag  = cpu_pc[c_word_size-1 : OFF_BITS+c_idx_bits];
  assign w_fidx = r_pc[OFF_BITS +: c_idx_bits];
  // A flush on the request cycle forces the lookup to miss.
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag) && !flush;

  // One selector serves both paths: the incoming line while filling, else the stored line.
  assign w_filling  = (r_state == IFC_MFILL);
  assign w_sel_line = w_filling ? {mem_out1, mem_out2} : r_data[w_idx];
  assign w_sel_off  = w_filling ? r_pc[OFF_BITS-1:0] : cpu_pc[OFF_BITS-1:0];

  ifc_word_select #(
    .OFF_BITS  (OFF_BITS),
    .LINE_BITS (c_line_bits)
  ) u_word_select (
    .line (w_sel_line),
    .off  (w_sel_off),
    .word (w_word)
  );

  // Control FSM: lookup in IDLE, issue the read in MREQ, capture and answer in MFILL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IFC_IDLE;
      r_pc         <= '0;
      r_valid      <= '0;
      inst_valid   <= 1'b0;
      inst         <= '0;
      mem_readable <= 1'b0;
      mem_in       <= '0;
      cpu_ready    <= 1'b1;
    end else begin
      inst_valid <= 1'b0;
      // Flush clears first; a fill write later in this block still wins for its line.
      if (flush) begin
        r_valid <= '0;
      end
      case (r_state)
        IFC_IDLE: begin
          if (cpu_req) begin
            r_pc <= cpu_pc;
            if (w_hit) begin
              inst_valid <= 1'b1;
              inst       <= w_word;
            end else begin
              r_state      <= IFC_MREQ;
              mem_readable <= 1'b1;
              mem_in       <= {cpu_pc[c_word_size-1:OFF_BITS], {OFF_BITS{1'b0}}};
              cpu_ready    <= 1'b0;
            end
          end
        end
        IFC_MREQ: begin
          mem_readable <= 1'b0;
          r_state      <= IFC_MFILL;
        end
        IFC_MFILL: begin
          r_valid[w_fidx] <= 1'b1;
          inst_valid      <= 1'b1;
          inst            <= w_word;
          cpu_ready       <= 1'b1;
          r_state         <= IFC_IDLE;
        end
        default: begin
          r_state <= IFC_IDLE;
        end
      endcase
    end
  end

  // Line storage: tag and data are only meaningful where the valid bit is set.
  always_ff @(posedge clk) begin
    if (r_state == IFC_MFILL) begin
      r_tag[w_fidx]  <= r_pc[c_word_size-1 : OFF_BITS+c_idx_bits];
      r_data[w_fidx] <= {mem_out1, mem_out2};
    end
  end

endmodule : inst_fetch_cache
`default_nettype wire

// File: tb/tb_inst_fetch_cache.sv
`default_nettype none
// ============================================================================
//  Module  : tb_inst_fetch_cache
//  Brief   : Self-checking bench for inst_fetch_cache with an instmem model
//            and a line-number based cache reference model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_inst_fetch_cache;
  import inst_fetch_cache_pkg::*;

  localparam int LINES = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req;
  logic [31:0]  cpu_pc;
  logic         flush;
  logic         cpu_ready;
  logic         inst_valid;
  logic [31:0]  inst;
  logic [31:0]  mem_in;
  logic         mem_readable;
  logic         mem_writable;
  logic [511:0] mem_write;
  logic [511:0] mem_out1 = '0;
  logic [511:0] mem_out2 = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  byte unsigned mem_arr [4096];
  bit           model_valid [LINES];
  logic [31:0]  model_line  [LINES];
  logic [31:0]  rd_q [$];

  inst_fetch_cache #(.LINES(LINES), .OFF_BITS(7)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_pc(cpu_pc), .flush(flush),
    .cpu_ready(cpu_ready), .inst_valid(inst_valid), .inst(inst),
    .mem_in(mem_in), .mem_readable(mem_readable), .mem_writable(mem_writable),
    .mem_write(mem_write), .mem_out1(mem_out1), .mem_out2(mem_out2)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a 4 KB table folded with the upper address bits.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return mem_arr[a[11:0]] ^ a[19:12] ^ a[27:20] ^ {4'b0, a[31:28]};
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    logic [31:0] a;
    a = {pc[31:2], 2'b00};
    return {mem_byte(a), mem_byte(a + 1), mem_byte(a + 2), mem_byte(a + 3)};
  endfunction

  // instmem: samples the read strobe at the edge and presents the whole line.
  always @(posedge clk) begin : b_instmem
    logic [1023:0] l;
    if (mem_readable) begin
      for (int k = 0; k < 128; k++) l[1023 - 8*k -: 8] = mem_byte(mem_in + k);
      mem_out1 <= l[1023:512];
      mem_out2 <= l[511:0];
    end
  end

  // Record every cycle the read strobe is up, with its address.
  always @(negedge clk) begin
    if (!rst && mem_readable) rd_q.push_back(mem_in);
  end

  // Reference model: each slot holds a whole line number (pc / 128).
  function automatic bit model_hit(input logic [31:0] pc, input bit fl);
    int idx;
    idx = int'((pc >> 7) % LINES);
    return !fl && model_valid[idx] && (model_line[idx] == (pc >> 7));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) model_valid[i] = 1'b0;
  endtask

  task automatic model_commit(input logic [31:0] pc, input bit fl, input bit hit, input bit flm);
    int idx;
    idx = int'((pc >> 7) % LINES);
    if (fl) model_clear();
    if (!hit) begin
      if (flm) model_clear();
      model_valid[idx] = 1'b1;
      model_line[idx]  = pc >> 7;
    end
  endtask

  // Issue one request and observe latency, returned word and instmem reads.
  task automatic fetch(input logic [31:0] pc, input bit fl, input bit flm,
                       output int lat, output logic [31:0] word,
                       output int nrd, output logic [31:0] rd_addr);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!cpu_ready && guard < 20) begin @(negedge clk); guard++; end
    rd_q.delete();
    cpu_req = 1'b1; cpu_pc = pc; flush = fl;
    @(posedge clk); #1;
    cpu_req = 1'b0; flush = flm; cpu_pc = $urandom;
    lat = 1;
    while (!inst_valid && lat < 10) begin
      @(posedge clk); #1;
      flush = 1'b0;
      lat++;
    end
    flush = 1'b0;
    word = inst;
    @(negedge clk);
    nrd = rd_q.size();
    rd_addr = (nrd > 0) ? rd_q[0] : 32'hDEAD_BEEF;
  endtask

  task automatic test_reset();
    n_cmp++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_ready got=%b want=1", cpu_ready); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid got=%b want=0", inst_valid); end
    n_cmp++; if (inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst got=%h want=0", inst); end
    n_cmp++; if (mem_readable !== 1'b0) begin n_fail++; $display("FAIL reset_mem_readable got=%b want=0", mem_readable); end
    n_cmp++; if (mem_in !== 32'h0) begin n_fail++; $display("FAIL reset_mem_in got=%h want=0", mem_in); end
    n_cmp++; if (mem_writable !== 1'b0 || mem_write !== '0) begin n_fail++; $display("FAIL reset_write_ties got=%b want=0", mem_writable); end
  endtask

  task automatic test_cold_miss();
    int lat, nrd; logic [31:0] w, ra;
    fetch(32'h0, 1'b0, 1'b0, lat, w, nrd, ra);
    model_commit(32'h0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL cold_latency got=%0d want=3", lat); end
    n_cmp++; if (w !== 32'h01020304) begin n_fail++; $display("FAIL cold_inst got=%h want=01020304", w); end
    n_cmp++; if (nrd !== 1 || ra !== 32'h0) begin n_fail++; $display("FAIL cold_memread got=%0d@%h want=1@0", nrd, ra); end
  endtask

  task automatic test_hit_streak();
    logic [31:0] pcs [3];
    pcs[0] = 32'h4; pcs[1] = 32'h8; pcs[2] = 32'hC;
    @(negedge clk);
    rd_q.delete();
    cpu_req = 1'b1; cpu_pc = pcs[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i < 2) cpu_pc = pcs[i+1]; else cpu_req = 1'b0;
      n_cmp++;
      if (inst_valid !== 1'b1 || inst !== exp_word(pcs[i])) begin
        n_fail++; $display("FAIL streak_hit%0d got=%b/%h want=1/%h", i, inst_valid, inst, exp_word(pcs[i]));
      end
    end
    @(negedge clk);
    n_cmp++; if (rd_q.size() !== 0) begin n_fail++; $display("FAIL streak_no_memread got=%0d want=0", rd_q.size()); end
  endtask

  task automatic test_second_half();
    int lat, nrd; logic [31:0] w, ra;
    fetch(32'h43, 1'b0, 1'b0, lat, w, nrd, ra);
    n_cmp++; if (lat !== 1 || nrd !== 0) begin n_fail++; $display("FAIL half2_hit got=lat%0d/rd%0d want=lat1/rd0", lat, nrd); end
    n_cmp++; if (w !== 32'hAABBCCDD) begin n_fail++; $display("FAIL half2_inst got=%h want=aabbccdd", w); end
  endtask

  task automatic test_conflict();
    int lat, nrd; logic [31:0] w, ra;
    logic [31:0] pcs [3];
    pcs[0] = 32'h000; pcs[1] = 32'h200; pcs[2] = 32'h000;
    // Lone flush pulse to start from an empty cache.
    @(negedge clk); flush = 1'b1; @(negedge clk); flush = 1'b0;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      fetch(pcs[i], 1'b0, 1'b0, lat, w, nrd, ra);
      model_commit(pcs[i], 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (lat !== 3 || nrd !== 1 || ra !== pcs[i] || w !== exp_word(pcs[i])) begin
        n_fail++; $display("FAIL conflict%0d got=lat%0d rd%0d@%h %h want=lat3 rd1@%h %h", i, lat, nrd, ra, w, pcs[i], exp_word(pcs[i]));
      end
    end
  endtask

  task automatic test_flush();
    int lat, nrd; logic [31:0] w, ra;
    fetch(32'h0, 1'b0, 1'b0, lat, w, nrd, ra);
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL flush_prehit got=lat%0d want=lat1", lat); end
    fetch(32'h0, 1'b1, 1'b0, lat, w, nrd, ra);
    model_commit(32'h0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (lat !== 3 || nrd !== 1 || ra !== 32'h0) begin n_fail++; $display("FAIL flush_with_req got=lat%0d rd%0d@%h want=lat3 rd1@0", lat, nrd, ra); end
    // Flush during MREQ: the fill for 0x100 survives, line 0 does not.
    fetch(32'h100, 1'b0, 1'b1, lat, w, nrd, ra);
    model_commit(32'h100, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (lat !== 3 || w !== exp_word(32'h100)) begin n_fail++; $display("FAIL flush_mreq_fill got=lat%0d %h want=lat3 %h", lat, w, exp_word(32'h100)); end
    fetch(32'h104, 1'b0, 1'b0, lat, w, nrd, ra);
    n_cmp++; if (lat !== 1 || nrd !== 0) begin n_fail++; $display("FAIL flush_mreq_keeps_fill got=lat%0d rd%0d want=lat1 rd0", lat, nrd); end
    fetch(32'h0, 1'b0, 1'b0, lat, w, nrd, ra);
    model_commit(32'h0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (lat !== 3 || nrd !== 1) begin n_fail++; $display("FAIL flush_mreq_clears_other got=lat%0d rd%0d want=lat3 rd1", lat, nrd); end
  endtask

  task automatic test_reset_mid_miss();
    int lat, nrd; logic [31:0] w, ra;
    bit saw;
    @(negedge clk);
    cpu_req = 1'b1; cpu_pc = 32'h180; flush = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b0; flush = 1'b0;
    n_cmp++; if (mem_readable !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_mreq got=%b want=1", mem_readable); end
    rst = 1'b1; #1;
    n_cmp++;
    if (cpu_ready !== 1'b1 || mem_readable !== 1'b0 || mem_in !== 32'h0 || inst_valid !== 1'b0 || inst !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_outputs got=rdy%b rd%b in%h v%b i%h want=rdy1 rd0 in0 v0 i0", cpu_ready, mem_readable, mem_in, inst_valid, inst);
    end
    saw = 1'b0;
    repeat (2) begin @(posedge clk); #1; saw |= inst_valid; end
    @(negedge clk); rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; saw |= inst_valid; end
    model_clear();
    n_cmp++; if (saw !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_valid got=%b want=0", saw); end
    fetch(32'h0, 1'b0, 1'b0, lat, w, nrd, ra);
    model_commit(32'h0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (lat !== 3 || nrd !== 1 || w !== 32'h01020304) begin n_fail++; $display("FAIL rstmid_refetch got=lat%0d rd%0d %h want=lat3 rd1 01020304", lat, nrd, w); end
  endtask

  task automatic test_random();
    int lat, nrd; logic [31:0] w, ra, pc, base;
    bit fl, flm, hit;
    int elat;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: base = 32'h0000_0000;
        1: base = 32'h0000_0200;
        2: base = 32'h0123_4400;
        default: base = 32'hFFFF_FE00;
      endcase
      pc  = base + 32'($urandom_range(0, 3) * 128) + 32'($urandom_range(0, 127));
      fl  = ($urandom_range(0, 7) == 0);
      hit = model_hit(pc, fl);
      flm = !hit && ($urandom_range(0, 5) == 0);
      elat = hit ? 1 : 3;
      fetch(pc, fl, flm, lat, w, nrd, ra);
      model_commit(pc, fl, hit, flm);
      n_cmp++;
      if (lat !== elat || w !== exp_word(pc) || nrd !== (hit ? 0 : 1) ||
          (!hit && ra !== {pc[31:7], 7'b0})) begin
        n_fail++;
        $display("FAIL random%0d pc=%h got=lat%0d rd%0d@%h %h want=lat%0d rd%0d@%h %h",
                 n, pc, lat, nrd, ra, w, elat, hit ? 0 : 1, {pc[31:7], 7'b0}, exp_word(pc));
      end
    end
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_pc = '0; flush = 1'b0;
    for (int i = 0; i < 4096; i++) mem_arr[i] = 8'($urandom);
    mem_arr[0] = 8'h01; mem_arr[1] = 8'h02; mem_arr[2] = 8'h03; mem_arr[3] = 8'h04;
    mem_arr[64] = 8'hAA; mem_arr[65] = 8'hBB; mem_arr[66] = 8'hCC; mem_arr[67] = 8'hDD;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); rst = 1'b0;
    test_cold_miss();
    test_hit_streak();
    test_second_half();
    test_conflict();
    test_flush();
    test_reset_mid_miss();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule : tb_inst_fetch_cache
`default_nettype wire
